serial_com_aligner: RTL
=======================

// Module: serial_com_aligner
// PURPOSE
//  Receive-side serial-to-parallel stage that feeds the 8-to-32 converter.
//  - Deserialises the MSB-first PHY bit stream on clk_32f.
//  - Hunts for the COM symbol (K28.5 payload 8'hBC) at any bit phase and locks byte alignment.
//  - Emits aligned bytes with a one-cycle strobe, a per-byte valid flag and a sync (active) flag.
// PARAMETERS
//  COM         8'hBC  alignment / idle symbol
//  LOCK_COUNT  4      consecutive aligned COMs needed to enter LOCKED (>=2)
// PORTS
//  clk_32f      input   1  bit-rate clock; all logic on posedge
//  reset        input   1  asynchronous, active-low reset
//  serial_in    input   1  serial data bit, MSB of each byte first
//  serial_valid input   1  line valid; low forces loss of alignment
//  data_out     output  8  last aligned byte
//  byte_strobe  output  1  one-cycle pulse when data_out updates
//  valid_out    output  1  data_out is payload (not COM); sampled with byte_strobe
//  active       output  1  alignment locked (sync to downstream)
// BEHAVIOUR
//  - Reset (reset==0, async): state=HUNT, sr=0, bit_cnt=0, com_cnt=0.
//    All outputs 0: data_out=8'h00, byte_strobe=0, valid_out=0, active=0.
//  - Shift register: nxt = {sr[6:0], serial_in}; sr<=nxt every clock while serial_valid=1.
//  - bit_cnt is 3 bits and wraps 7->0. A byte boundary occurs when bit_cnt==7; that byte is nxt.
//  - States:
//    HUNT: bit_cnt and com_cnt ignored. If nxt==COM -> ALIGN, bit_cnt<=0, com_cnt<=1.
//    ALIGN: bit_cnt++. At a boundary:
//      * nxt==COM and com_cnt+1==LOCK_COUNT -> LOCKED, active<=1.
//      * nxt==COM otherwise -> com_cnt++.
//      * nxt!=COM -> HUNT, com_cnt<=0.
//        No bit-level re-search happens on that cycle; searching resumes next clock.
//    LOCKED: bit_cnt++. At a boundary:
//      data_out<=nxt, byte_strobe<=1, valid_out<=(nxt!=COM).
//      A non-COM byte never causes unlock.
//  - byte_strobe is high for exactly one cycle per boundary in LOCKED, and is 0 in HUNT and ALIGN.
//  - data_out and valid_out hold between strobes. In HUNT and ALIGN, valid_out=0.
//  - Latency: last bit of a byte sampled at edge N -> data_out and strobe visible after edge N.
//    Output is registered, one byte every 8 clocks.
//  - The lock transition itself produces no strobe. The first strobe comes 8 clocks after active rises.
//  - serial_valid==0 on any clock, in any state, has the following effect at the next edge:
//    state->HUNT, active->0, byte_strobe->0, valid_out->0, com_cnt->0, bit_cnt->0.
//    sr is not shifted, and data_out holds its value.
//  - Counter widths: com_cnt is sized $clog2(LOCK_COUNT+1) and saturates, never wraps.
//  - Reset mid-operation (any state) returns immediately to the reset values above.
// TESTING
//  1. Reset asserted, then 16 clocks of serial_in=1
//     -> all outputs 0, state HUNT (no false COM, since 8'hFF != COM).
//  2. Three junk bits (1,0,1), then four COM bytes 8'hBC
//     -> active rises one edge after the last bit of the 4th COM; no byte_strobe yet.
//  3. After lock, send 8'h5A
//     -> one byte_strobe pulse with data_out=8'h5A, valid_out=1. Then send COM
//     -> data_out=8'hBC, valid_out=0.
//  4. Two COMs, then 8'h3C
//     -> return to HUNT, active stays 0. Four further COMs -> lock.
//  5. While LOCKED, serial_valid=0 for one clock
//     -> active=0 and valid_out=0 next edge, data_out held. Relock needs LOCK_COUNT COMs.
//  6. Assert reset mid-byte in LOCKED
//     -> all outputs 0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/serial_com_aligner_if.sv
// serial_com_aligner_if
//   Bundles the PHY-side serial input and the aligned byte output of the
//   receive aligner. Clock and reset are not part of the bundle.
//   master : driver of the serial line and consumer of the aligned bytes
//   slave  : the aligner itself
//   serial_in    PHY data bit, MSB of each byte first
//   serial_valid line valid; low drops alignment
//   data_out     last aligned byte
//   byte_strobe  one-cycle pulse when data_out updates
//   valid_out    data_out carries payload (not COM)
//   active       alignment locked
interface serial_com_aligner_if;
    logic       serial_in;
    logic       serial_valid;
    logic [7:0] data_out;
    logic       byte_strobe;
    logic       valid_out;
    logic       active;

    modport master (
        output serial_in, serial_valid,
        input  data_out, byte_strobe, valid_out, active
    );

    modport slave (
        input  serial_in, serial_valid,
        output data_out, byte_strobe, valid_out, active
    );
endinterface

// File: rtl/serial_com_aligner.sv
// serial_com_aligner
//   Deserialises an MSB-first bit stream, hunts for the COM symbol at any
//   bit phase, and after LOCK_COUNT consecutive byte-aligned COMs emits
//   aligned bytes with a one-cycle strobe.
//   clk_32f : bit-rate clock, posedge
//   reset   : asynchronous, active-low
//   bus     : serial_com_aligner_if.slave (serial in, aligned byte out)
module serial_com_aligner #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic                  clk_32f,
    input  logic                  reset,
    serial_com_aligner_if.slave   bus
);
    localparam int CW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [7:0]      sr_q, sr_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   com_cnt_q, com_cnt_d;
    logic [7:0]      data_q, data_d;
    logic            strobe_q, strobe_d;
    logic            valid_q, valid_d;
    logic            active_q, active_d;

    logic [7:0]      nxt;
    logic            boundary;
    logic            is_com;
    logic            lock_hit;

    assign nxt      = {sr_q[6:0], bus.serial_in};
    assign boundary = (bit_cnt_q == 3'd7);
    assign is_com   = (nxt == COM);
    assign lock_hit = ((int'(com_cnt_q) + 1) == LOCK_COUNT);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q   <= HUNT;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            data_q    <= '0;
            strobe_q  <= 1'b0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        strobe_d  = 1'b0;
        valid_d   = valid_q;
        active_d  = active_q;

        if (!bus.serial_valid) begin
            // Line dropped: lose alignment, freeze sr, keep last data byte.
            state_d   = HUNT;
            active_d  = 1'b0;
            valid_d   = 1'b0;
            com_cnt_d = '0;
            bit_cnt_d = '0;
        end else begin
            sr_d = nxt;
            case (state_q)
                HUNT: begin
                    // bit phase search: COM seen ends a byte, so next bit is bit 0
                    if (is_com) begin
                        state_d   = ALIGN;
                        bit_cnt_d = '0;
                        com_cnt_d = CW'(1);
                    end
                end
                ALIGN: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (boundary) begin
                        if (is_com && lock_hit) begin
                            state_d  = LOCKED;
                            active_d = 1'b1;
                        end else if (is_com) begin
                            if (int'(com_cnt_q) < LOCK_COUNT)
                                com_cnt_d = com_cnt_q + CW'(1);
                        end else begin
                            // no re-search this cycle; HUNT resumes next clock
                            state_d   = HUNT;
                            com_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (boundary) begin
                        data_d   = nxt;
                        strobe_d = 1'b1;
                        valid_d  = !is_com;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign bus.data_out    = data_q;
    assign bus.byte_strobe = strobe_q;
    assign bus.valid_out   = valid_q;
    assign bus.active      = active_q;
endmodule
